// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a counted burst from a FIFO read port onto a valid/ready stream
// Ports: i_clk/i_rst_n clock and async active-low reset; i_start/i_len launch a transfer;
// o_busy/o_done/o_rd_cnt report progress; o_fifo_rd_en/i_fifo_empty/i_fifo_data face the
// upstream FIFO; o_valid/o_data/o_last/i_ready form the downstream stream.
module fifo_rd_stream #(
  parameter int WIDTH = 32,
  parameter string FWFT = "FALSE",
  parameter int LEN_WIDTH = 16,
  parameter int BUF_DEPTH = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [LEN_WIDTH-1:0] i_len,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_fifo_rd_en,
  input  logic                 i_fifo_empty,
  input  logic [WIDTH-1:0]     i_fifo_data,
  output logic                 o_valid,
  output logic [WIDTH-1:0]     o_data,
  output logic                 o_last,
  input  logic                 i_ready,
  output logic [LEN_WIDTH-1:0] o_rd_cnt
);
  localparam logic [1:0] IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2, DONE = 2'd3;
  localparam bit FT = FWFT == "TRUE";
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH + 2) + 1;
  localparam logic [PW-1:0] PMAX = PW'(BUF_DEPTH - 1);
  logic [1:0] state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d, issued_q, issued_d, rd_cnt_q, rd_cnt_d;
  logic inflight_q, inflight_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [WIDTH-1:0] mem_d [BUF_DEPTH];
  logic pop, cap, start_ok;
  assign o_valid = count_q != '0;
  assign pop = o_valid & i_ready;
  // a word in flight already owns a buffer slot; a same-cycle pop frees one
  assign o_fifo_rd_en = state_q == READ && !i_fifo_empty && issued_q < len_q &&
                        count_q + CW'(inflight_q) - CW'(pop) < CW'(BUF_DEPTH);
  assign cap = FT ? o_fifo_rd_en : inflight_q;
  assign o_data = o_valid ? mem_q[rd_ptr_q] : '0;
  assign o_last = o_valid && rd_cnt_q == len_q - LEN_WIDTH'(1);
  assign o_busy = state_q != IDLE;
  assign o_done = state_q == DONE;
  assign o_rd_cnt = rd_cnt_q;
  always_comb begin
    start_ok = state_q == IDLE && i_start;
    len_d = start_ok ? i_len : len_q;
    issued_d = start_ok ? '0 : issued_q + LEN_WIDTH'(o_fifo_rd_en);
    rd_cnt_d = start_ok ? '0 : rd_cnt_q + LEN_WIDTH'(pop);
    inflight_d = !FT && o_fifo_rd_en;
    count_d = count_q + CW'(cap) - CW'(pop);
    wr_ptr_d = cap ? (wr_ptr_q == PMAX ? '0 : wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d = pop ? (rd_ptr_q == PMAX ? '0 : rd_ptr_q + PW'(1)) : rd_ptr_q;
    mem_d = mem_q;
    if (cap) mem_d[wr_ptr_q] = i_fifo_data;
    state_d = state_q == IDLE  ? (i_start ? (i_len == '0 ? DONE : READ) : IDLE) :
              state_q == READ  ? (issued_d == len_q ? DRAIN : READ) :
              state_q == DRAIN ? (rd_cnt_d == len_q ? DONE : DRAIN) : IDLE;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q <= IDLE;
      len_q <= '0;
      issued_q <= '0;
      rd_cnt_q <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      mem_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      issued_q <= issued_d;
      rd_cnt_q <= rd_cnt_d;
      inflight_q <= inflight_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      mem_q <= mem_d;
    end
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: runs a FWFT=FALSE and a FWFT=TRUE instance side by side against a stream model
module tb_fifo_rd_stream;
  localparam int W = 32, LW = 16, BD = 2;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, ready = 1'b0;
  logic [LW-1:0] len = '0;
  logic busy [2], done [2], rd_en [2], fempty [2], valid [2], last [2];
  logic [W-1:0] fdata [2], data [2];
  logic [LW-1:0] rd_cnt [2];
  logic [W-1:0] fmem [2][1024];
  int fhead [2] = '{0, 0};
  int ftail [2] = '{0, 0};
  logic [W-1:0] fd0 = '0;
  int n_cmp = 0, n_err = 0, cyc = 0, mode = 0, pend = 0, tc = -1;
  bit m_act [2], e_done [2], pv [2], pr [2];
  int acc [2], mlen [2], nexp [2], outst [2], dcnt [2];
  logic tr_rd [2][48], tr_v [2][48], tr_l [2][48], tr_dn [2][48];
  logic [W-1:0] tr_d [2][48];

  always #5 clk = ~clk;

  fifo_rd_stream #(.WIDTH(W), .FWFT("FALSE"), .LEN_WIDTH(LW), .BUF_DEPTH(BD)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_len(len), .o_busy(busy[0]),
    .o_done(done[0]), .o_fifo_rd_en(rd_en[0]), .i_fifo_empty(fempty[0]),
    .i_fifo_data(fdata[0]), .o_valid(valid[0]), .o_data(data[0]), .o_last(last[0]),
    .i_ready(ready), .o_rd_cnt(rd_cnt[0]));
  fifo_rd_stream #(.WIDTH(W), .FWFT("TRUE"), .LEN_WIDTH(LW), .BUF_DEPTH(BD)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_len(len), .o_busy(busy[1]),
    .o_done(done[1]), .o_fifo_rd_en(rd_en[1]), .i_fifo_empty(fempty[1]),
    .i_fifo_data(fdata[1]), .o_valid(valid[1]), .o_data(data[1]), .o_last(last[1]),
    .i_ready(ready), .o_rd_cnt(rd_cnt[1]));

  // upstream FIFOs: registered read data for instance 0, first-word-fall-through for instance 1
  assign fempty[0] = fhead[0] == ftail[0];
  assign fempty[1] = fhead[1] == ftail[1];
  assign fdata[0] = fd0;
  assign fdata[1] = fmem[1][fhead[1] & 1023];
  always @(posedge clk)
    for (int k = 0; k < 2; k++)
      if (rd_en[k] && fhead[k] != ftail[k]) fhead[k] <= fhead[k] + 1;
  always @(posedge clk) if (rd_en[0]) fd0 <= fmem[0][fhead[0] & 1023];

  task automatic chk(input int k, input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] @cyc %0d: got %0h, want %0h", nm, k, cyc, act, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] v);
    for (int k = 0; k < 2; k++) begin
      fmem[k][ftail[k] & 1023] = v;
      ftail[k]++;
    end
  endtask

  task automatic do_reset;
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 0; e_done[k] = 0; pv[k] = 0; pr[k] = 0;
      acc[k] = 0; mlen[k] = 0; outst[k] = 0; dcnt[k] = 0; nexp[k] = ftail[k];
    end
  endtask

  // expected stream = words in push order; a transfer ends one cycle after its len-th handshake
  task automatic cmp_cycle;
    for (int k = 0; k < 2; k++) begin
      bit was_act, nd;
      was_act = m_act[k];
      nd = 0;
      chk(k, "rd_en_while_empty", rd_en[k] & fempty[k], 0);
      chk(k, "occupancy_le_depth", outst[k] <= BD, 1);
      chk(k, "busy", busy[k], m_act[k]);
      chk(k, "done", done[k], e_done[k]);
      chk(k, "rd_cnt", rd_cnt[k], acc[k]);
      if (pv[k] && !pr[k]) chk(k, "valid_held", valid[k], 1);
      if (valid[k]) begin
        chk(k, "word_expected", nexp[k] < ftail[k], 1);
        chk(k, "data", data[k], fmem[k][nexp[k] & 1023]);
        chk(k, "last", last[k], acc[k] == mlen[k] - 1);
      end
      if (tc >= 0 && tc < 48) begin
        tr_rd[k][tc] = rd_en[k]; tr_v[k][tc] = valid[k]; tr_l[k][tc] = last[k];
        tr_dn[k][tc] = done[k]; tr_d[k][tc] = data[k];
      end
      if (rd_en[k]) outst[k]++;
      if (done[k]) dcnt[k]++;
      if (e_done[k]) m_act[k] = 0;
      if (valid[k] && ready) begin
        acc[k]++; nexp[k]++; outst[k]--;
        nd = acc[k] == mlen[k];
      end
      if (!was_act && start) begin
        m_act[k] = 1; mlen[k] = int'(len); acc[k] = 0; dcnt[k] = 0;
        nd = len == '0;
      end
      e_done[k] = nd;
      pv[k] = valid[k];
      pr[k] = ready;
    end
    if (tc >= 0) tc++;
  endtask

  task automatic step;
    @(negedge clk);
    if (rst_n) cmp_cycle();
    @(posedge clk);
    #1;
    cyc++;
    ready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'($urandom_range(0, 1));
  endtask

  task automatic kick(input int l);
    start = 1'b1;
    len = LW'(l);
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int l);
    for (int i = 0; i < 3000 && !(dcnt[0] > 0 && dcnt[1] > 0); i++) begin
      if (pend > 0 && $urandom_range(0, 2) != 0) begin
        push($urandom);
        pend--;
      end
      step();
    end
    for (int k = 0; k < 2; k++) begin
      chk(k, "done_once", dcnt[k], 1);
      chk(k, "final_rd_cnt", rd_cnt[k], l);
    end
    step();
  endtask

  task automatic chk_zero;
    for (int k = 0; k < 2; k++) begin
      chk(k, "rst_busy", busy[k], 0);
      chk(k, "rst_done", done[k], 0);
      chk(k, "rst_rd_en", rd_en[k], 0);
      chk(k, "rst_valid", valid[k], 0);
      chk(k, "rst_data", data[k], 0);
      chk(k, "rst_last", last[k], 0);
      chk(k, "rst_rd_cnt", rd_cnt[k], 0);
    end
  endtask

  // hand-derived timeline: rd_en on cycles 1..l, first word 3 cycles after start (FALSE) or 2 (TRUE)
  task automatic run_trace(input int l);
    mode = 0;
    ready = 1'b1;
    pend = 0;
    for (int i = 0; i < l; i++) push(W'(i));
    tc = 0;
    kick(l);
    wait_done(l);
    tc = -1;
    for (int k = 0; k < 2; k++) begin
      int lat;
      lat = k == 0 ? 3 : 2;
      for (int c = 0; c <= l + 3; c++) begin
        chk(k, "trace_rd_en", tr_rd[k][c], c >= 1 && c <= l);
        chk(k, "trace_valid", tr_v[k][c], c >= lat && c < lat + l);
        chk(k, "trace_done", tr_dn[k][c], c == lat + l);
        if (c >= lat && c < lat + l) begin
          chk(k, "trace_data", tr_d[k][c], c - lat);
          chk(k, "trace_last", tr_l[k][c], c == lat + l - 1);
        end
      end
    end
  endtask

  initial begin
    int gr, gb;
    do_reset();
    repeat (3) step();
    chk_zero();
    rst_n = 1'b1;
    run_trace(8);
    pend = 0;
    for (int i = 0; i < 16; i++) push(W'(i));
    mode = 1;
    kick(16);
    wait_done(16);
    mode = 0;
    for (int i = 0; i < 3; i++) push(W'(i));
    kick(6);
    gr = 0;
    gb = 0;
    for (int c = 1; c <= 13; c++) begin
      if (c >= 4)
        for (int k = 0; k < 2; k++) begin
          gr += int'(rd_en[k]);
          gb += int'(busy[k]);
        end
      step();
    end
    chk(0, "gap_rd_en_count", gr, 0);
    chk(0, "gap_busy_cycles", gb, 20);
    for (int i = 3; i < 6; i++) push(W'(i));
    wait_done(6);
    kick(0);
    gr = 0;
    for (int c = 0; c < 6; c++) begin
      for (int k = 0; k < 2; k++) gr += int'(rd_en[k]) + int'(valid[k]);
      step();
    end
    chk(0, "zero_len_activity", gr, 0);
    wait_done(0);
    for (int i = 0; i < 4; i++) push(W'(100 + i));
    kick(4);
    step();
    step();
    kick(3);
    wait_done(4);
    run_trace(4);
    for (int t = 0; t < 8; t++) begin
      int l, pre;
      l = $urandom_range(1, 24);
      pre = $urandom_range(0, l);
      mode = $urandom_range(1, 2);
      for (int i = 0; i < pre; i++) push($urandom);
      pend = l - pre;
      kick(l);
      wait_done(l);
    end
    mode = 0;
    pend = 0;
    for (int i = 0; i < 10; i++) push($urandom);
    kick(10);
    for (int i = 0; i < 100 && rd_cnt[0] < 5; i++) step();
    chk(0, "reached_five_words", rd_cnt[0] >= 5, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero();
    for (int k = 0; k < 2; k++) ftail[k] = fhead[k];
    do_reset();
    repeat (2) step();
    rst_n = 1'b1;
    step();
    run_trace(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
